// File: rtl/fpu_pkg.sv
// Shared FPU constants and the packed single-precision layout.
// Used by the add, multiply and normalise stages.
package fpu_pkg;

  localparam int FP_EXP_BIAS    = 127;
  localparam int FP_EXP_MAX     = 255;
  localparam int FP_MANT_W      = 23;
  localparam int SUM_HIDDEN_BIT = 30;
  localparam int SUM_GUARD_BIT  = 6;

  typedef struct packed {
    logic                 sign;
    logic [7:0]           exp;
    logic [FP_MANT_W-1:0] frac;
  } fp32_t;

endpackage

// File: rtl/fpu_normalize_if.sv
// Add-stage sum in, packed single plus writeback destination out.
// The flag signal exists only when FPU_NORM_FLAGS_EN is defined.
interface fpu_normalize_if;

  logic        add_valid;
  logic [31:0] add_mantissa;
  logic [7:0]  add_exponent;
  logic        add_sign;
  logic [4:0]  add_dest;
  logic        fpu_result_valid;
  logic [31:0] fpu_result;
  logic [4:0]  fpu_result_dest;
`ifdef FPU_NORM_FLAGS_EN
  logic [2:0]  fpu_result_flags;
`endif

  modport master (
`ifdef FPU_NORM_FLAGS_EN
    input  fpu_result_flags,
`endif
    output add_valid, add_mantissa, add_exponent, add_sign, add_dest,
    input  fpu_result_valid, fpu_result, fpu_result_dest
  );

  modport slave (
`ifdef FPU_NORM_FLAGS_EN
    output fpu_result_flags,
`endif
    input  add_valid, add_mantissa, add_exponent, add_sign, add_dest,
    output fpu_result_valid, fpu_result, fpu_result_dest
  );

endinterface

// File: rtl/fpu_lzc32.sv
// Leading-zero counter for a 31-bit vector; all-zero input reports 31.
// Pairwise (all-zero, count) merge tree, five levels deep.
module fpu_lzc32 (
  input  logic [30:0] vec,
  output logic [4:0]  count
);

  logic [31:0] v;
  logic [15:0] z1;
  logic [15:0] c1;
  logic [7:0]  z2;
  logic [1:0]  c2 [8];
  logic [3:0]  z3;
  logic [2:0]  c3 [4];
  logic [1:0]  z4;
  logic [3:0]  c4 [2];
  logic        z5;
  logic [4:0]  c5;

  always_comb begin
    v = {vec, 1'b0};
    for (int i = 0; i < 16; i++) begin
      z1[i] = ~(v[2*i+1] | v[2*i]);
      c1[i] = ~v[2*i+1];
    end
    // Left child is the higher index; when it is all-zero the count continues into the right child.
    for (int i = 0; i < 8; i++) begin
      z2[i] = z1[2*i+1] & z1[2*i];
      c2[i] = z1[2*i+1] ? {1'b1, c1[2*i]} : {1'b0, c1[2*i+1]};
    end
    for (int i = 0; i < 4; i++) begin
      z3[i] = z2[2*i+1] & z2[2*i];
      c3[i] = z2[2*i+1] ? {1'b1, c2[2*i]} : {1'b0, c2[2*i+1]};
    end
    for (int i = 0; i < 2; i++) begin
      z4[i] = z3[2*i+1] & z3[2*i];
      c4[i] = z3[2*i+1] ? {1'b1, c3[2*i]} : {1'b0, c3[2*i+1]};
    end
    z5    = z4[1] & z4[0];
    c5    = z4[1] ? {1'b1, c4[0]} : {1'b0, c4[1]};
    count = z5 ? 5'd31 : c5;
  end

endmodule

// File: rtl/fpu_normalize.sv
// Normalise, round to nearest-even and pack the add/sub sum; 3-cycle, fully pipelined.
// Define FPU_NORM_FLAGS_EN to add the {overflow, underflow, inexact} result flags.
module fpu_normalize
  import fpu_pkg::*;
#(
  parameter int LATENCY = 3
) (
  input  logic           clock,
  input  logic           resetn,
  fpu_normalize_if.slave bus
);

  localparam logic signed [9:0] EXP_INF = 10'(FP_EXP_MAX);

  if (LATENCY != 3) begin : g_latency_check
    $error("fpu_normalize: LATENCY is fixed at 3");
  end

  logic [1:0]  vld_q;
  logic [4:0]  lz_nx;

  logic [31:0] s1_mant;
  logic [7:0]  s1_exp;
  logic        s1_sign, s1_ovf, s1_zero;
  logic [4:0]  s1_lz, s1_dest;

  logic [30:0]        s2_mant;
  logic signed [9:0]  s2_exp;
  logic               s2_sign, s2_zero;
  logic [4:0]         s2_dest;

  logic [4:0]         shamt;
  logic signed [9:0]  e_in, exp_nx;
  logic [30:0]        mant_nx;

  logic [23:0]        sig, sig_r;
  logic [24:0]        sum;
  logic               g, st, rnd, is_inf;
  logic signed [9:0]  exp_r;
  logic [7:0]         field;
  fp32_t              res_nx;

  fpu_lzc32 u_lzc (
    .vec   (bus.add_mantissa[30:0]),
    .count (lz_nx)
  );

  always_comb begin
    e_in = signed'({2'b00, s1_exp});
    // Never shift the exponent below 1: the excess stays in the mantissa as a subnormal.
    if (e_in - signed'({5'b00000, s1_lz}) < 10'sd1) shamt = s1_exp[4:0] - 5'd1;
    else                                            shamt = s1_lz;
    if (s1_ovf) begin
      mant_nx = {s1_mant[31:2], s1_mant[1] | s1_mant[0]};
      exp_nx  = e_in + 10'sd1;
    end else begin
      mant_nx = s1_mant[30:0] << shamt;
      exp_nx  = e_in - signed'({5'b00000, shamt});
    end
  end

  always_comb begin
    sig = s2_mant[SUM_HIDDEN_BIT -: 24];
    g   = s2_mant[SUM_GUARD_BIT];
    st  = |s2_mant[SUM_GUARD_BIT-1:0];
    rnd = g & (st | sig[0]);
    sum = {1'b0, sig} + {24'd0, rnd};
    if (sum[24]) begin
      sig_r = sum[24:1];
      exp_r = s2_exp + 10'sd1;
    end else begin
      sig_r = sum[23:0];
      exp_r = s2_exp;
    end
    is_inf = (exp_r >= EXP_INF);
    // A subnormal that rounds up into bit 23 picks up its exponent field of 1 here.
    field  = sig_r[23] ? exp_r[7:0] : 8'h00;
    res_nx = '0;
    if (!s2_zero) begin
      res_nx.sign = s2_sign;
      if (is_inf) begin
        res_nx.exp  = 8'(FP_EXP_MAX);
        res_nx.frac = '0;
      end else begin
        res_nx.exp  = field;
        res_nx.frac = sig_r[FP_MANT_W-1:0];
      end
    end
  end

  always_ff @(posedge clock) begin
    s1_mant <= bus.add_mantissa;
    s1_exp  <= bus.add_exponent;
    s1_sign <= bus.add_sign;
    s1_ovf  <= bus.add_mantissa[31];
    s1_lz   <= lz_nx;
    s1_zero <= (bus.add_mantissa == 32'd0);
    s1_dest <= bus.add_dest;
    s2_mant <= mant_nx;
    s2_exp  <= exp_nx;
    s2_sign <= s1_sign;
    s2_zero <= s1_zero;
    s2_dest <= s1_dest;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      vld_q                <= '0;
      bus.fpu_result_valid <= 1'b0;
      bus.fpu_result       <= '0;
      bus.fpu_result_dest  <= '0;
`ifdef FPU_NORM_FLAGS_EN
      bus.fpu_result_flags <= '0;
`endif
    end else begin
      vld_q                <= {vld_q[0], bus.add_valid};
      bus.fpu_result_valid <= vld_q[1];
      bus.fpu_result       <= res_nx;
      bus.fpu_result_dest  <= s2_dest;
`ifdef FPU_NORM_FLAGS_EN
      bus.fpu_result_flags <= {is_inf & ~s2_zero,
                               (field == 8'h00) & ~is_inf & ~s2_zero & (g | st),
                               ~s2_zero & (g | st)};
`endif
    end
  end

  a_no_special_exp: assert property (@(posedge clock) disable iff (!resetn)
    bus.add_valid |-> bus.add_exponent != 8'hFF);

endmodule

// File: tb/tb_fpu_normalize.sv
// Directed bench for fpu_normalize: hand-computed vectors, throughput and mid-stream reset.
module tb_fpu_normalize;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  int   errors = 0;
  int   checks = 0;

  fpu_normalize_if bus ();

  fpu_normalize dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] m, input logic [7:0] e,
                       input logic s, input logic [4:0] d);
    bus.add_valid    = v;
    bus.add_mantissa = m;
    bus.add_exponent = e;
    bus.add_sign     = s;
    bus.add_dest     = d;
  endtask

  task automatic run_one(input string tag, input logic [31:0] m, input logic [7:0] e,
                         input logic s, input logic [4:0] d, input logic [31:0] expv);
    drive(1'b1, m, e, s, d);
    @(posedge clock); #1;
    drive(1'b0, $urandom, 8'd77, 1'b1, 5'd31);
    @(posedge clock); #1;
    check({tag, "_early_vld"}, 32'(bus.fpu_result_valid), 32'd0);
    @(posedge clock); #1;
    check({tag, "_vld"},  32'(bus.fpu_result_valid), 32'd1);
    check({tag, "_res"},  bus.fpu_result, expv);
    check({tag, "_dest"}, 32'(bus.fpu_result_dest), 32'(d));
  endtask

  initial begin
    drive(1'b0, 32'd0, 8'd1, 1'b0, 5'd0);
    resetn = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_vld",  32'(bus.fpu_result_valid), 32'd0);
    check("rst_res",  bus.fpu_result, 32'd0);
    check("rst_dest", 32'(bus.fpu_result_dest), 32'd0);
    resetn = 1'b1;

    run_one("one_plus_one", 32'h8000_0000, 8'd127, 1'b0, 5'd3,  32'h4000_0000);
    run_one("tie_even",     32'h4000_0040, 8'd127, 1'b0, 5'd4,  32'h3F80_0000);
    run_one("tie_up",       32'h4000_00C0, 8'd127, 1'b0, 5'd5,  32'h3F80_0002);
`ifdef FPU_NORM_FLAGS_EN
    check("tie_up_flags", 32'(bus.fpu_result_flags), 32'b001);
`endif
    run_one("subnormal",    32'h2000_0000, 8'd1,   1'b0, 5'd6,  32'h0040_0000);
`ifdef FPU_NORM_FLAGS_EN
    check("subnormal_flags", 32'(bus.fpu_result_flags), 32'b000);
`endif
    run_one("zero",         32'h0000_0000, 8'd90,  1'b0, 5'd7,  32'h0000_0000);
    run_one("overflow",     32'h8000_0000, 8'd254, 1'b1, 5'd8,  32'hFF80_0000);
`ifdef FPU_NORM_FLAGS_EN
    check("overflow_flags", 32'(bus.fpu_result_flags), 32'b100);
`endif
    run_one("shift2",       32'h1000_0000, 8'd127, 1'b0, 5'd9,  32'h3E80_0000);
    run_one("shift23",      32'h0000_0080, 8'd127, 1'b1, 5'd10, 32'hB400_0000);
    run_one("round_carry",  32'h7FFF_FFC0, 8'd127, 1'b0, 5'd11, 32'h4000_0000);
    run_one("sub_to_norm",  32'h3FFF_FFC0, 8'd1,   1'b0, 5'd12, 32'h0080_0000);
`ifdef FPU_NORM_FLAGS_EN
    check("sub_to_norm_flags", 32'(bus.fpu_result_flags), 32'b001);
`endif
    run_one("ovf_sticky",   32'h8000_00C0, 8'd127, 1'b0, 5'd13, 32'h4000_0001);
    run_one("sub_clamp",    32'h0100_0000, 8'd3,   1'b0, 5'd14, 32'h0008_0000);
    run_one("sub_inexact",  32'h2000_0040, 8'd1,   1'b0, 5'd15, 32'h0040_0000);
`ifdef FPU_NORM_FLAGS_EN
    check("sub_inexact_flags", 32'(bus.fpu_result_flags), 32'b011);
`endif

    // Back-to-back stream: op k enters after edge k and leaves after edge k+3.
    for (int k = 0; k < 10; k++) begin
      if (k < 8) drive(1'b1, 32'h8000_0000, 8'(100 + k), k[0], 5'(3 * k + 1));
      else       drive(1'b0, 32'h8000_0000, 8'd100, 1'b0, 5'd0);
      @(posedge clock); #1;
      if (k >= 2) begin
        check($sformatf("stream%0d_vld", k - 2),  32'(bus.fpu_result_valid), 32'd1);
        check($sformatf("stream%0d_res", k - 2),  bus.fpu_result,
              {(k - 2) % 2 == 1, 8'(101 + k - 2), 23'd0});
        check($sformatf("stream%0d_dest", k - 2), 32'(bus.fpu_result_dest), 32'(3 * (k - 2) + 1));
      end
    end
    @(posedge clock); #1;
    check("stream_end_vld", 32'(bus.fpu_result_valid), 32'd0);

    // Reset asserted on the third cycle of a stream discards everything in flight.
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 32'h4000_0000, 8'(120 + k), 1'b0, 5'(20 + k));
      @(posedge clock); #1;
    end
    drive(1'b1, 32'h4000_0000, 8'd122, 1'b0, 5'd22);
    resetn = 1'b0;
    @(posedge clock); #1;
    check("midrst_vld",  32'(bus.fpu_result_valid), 32'd0);
    check("midrst_res",  bus.fpu_result, 32'd0);
    check("midrst_dest", 32'(bus.fpu_result_dest), 32'd0);
    drive(1'b0, 32'h4000_0000, 8'd123, 1'b0, 5'd23);
    @(posedge clock); #1;
    resetn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clock); #1;
      check($sformatf("post_rst%0d_vld", k), 32'(bus.fpu_result_valid), 32'd0);
    end

    run_one("after_rst", 32'h8000_0000, 8'd127, 1'b0, 5'd2, 32'h4000_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
